// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider controller.
package clk_div_pkg;

    // Default width of the half-period counter.
    localparam int CLK_DIV_WIDTH = 8;

    // Controller state encoding.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } clk_div_state_e;

endpackage

// File: rtl/clk_div_core.sv
// Phase counter and output toggle for the clock divider.
// Counts 0..cur_div-1 within each half period; at the last count the output
// toggles. A load strobe replaces the divisor at the edge it is asserted on,
// and clear forces the output low with the counter at zero.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int WIDTH       = CLK_DIV_WIDTH,
    parameter int DEFAULT_DIV = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_div_i,
    output logic             clk_out_o,
    output logic             tick_o,
    output logic             rise_bnd_o,
    output logic             fall_bnd_o,
    output logic [WIDTH-1:0] cur_div_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] cur_div_q;
    logic             clk_out_q;
    logic             tick_q;
    logic             phase_end;

    // Boundaries are reported unqualified; the controller decides when they count.
    assign phase_end  = (count_q == (cur_div_q - 1'b1));
    assign rise_bnd_o = phase_end && !clk_out_q;
    assign fall_bnd_o = phase_end &&  clk_out_q;

    assign clk_out_o = clk_out_q;
    assign tick_o    = tick_q;
    assign cur_div_o = cur_div_q;

    // Half-period counting, output toggle, tick generation and divisor load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q   <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            cur_div_q <= WIDTH'(DEFAULT_DIV);
        end else begin
            if (clear_i) begin
                count_q   <= '0;
                clk_out_q <= 1'b0;
            end else if (run_i) begin
                if (phase_end) begin
                    count_q   <= '0;
                    clk_out_q <= !clk_out_q;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
            tick_q <= run_i && !clear_i && rise_bnd_o;
            if (load_i) begin
                cur_div_q <= load_div_i;
            end
        end
    end

endmodule

// File: rtl/clk_div_ctrl.sv
// Runtime-programmable clock divider controller with glitch-free reconfiguration.
// Config requests are buffered in a one-deep pending register and applied only
// at phase boundaries so the divided clock never carries a runt pulse.
// Optional: define CLK_DIV_CTRL_EDGE_CNT_EN to add the saturating edge_cnt output.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int WIDTH         = CLK_DIV_WIDTH,
    parameter int DEFAULT_DIV   = 1,
    parameter bit START_ENABLED = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic             cfg_en,
    input  logic [WIDTH-1:0] cfg_div,
    output logic             cfg_err,
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    output logic [15:0]      edge_cnt,
`endif
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic [WIDTH-1:0] cur_div
);

    clk_div_state_e   state_q;
    logic             pend_vld_q;
    logic             pend_en_q;
    logic [WIDTH-1:0] pend_div_q;
    logic             cfg_err_q;

    logic             core_run;
    logic             core_clear;
    logic             core_load;
    logic             rise_bnd;
    logic             fall_bnd;
    logic             accept;

    assign accept    = cfg_valid && !pend_vld_q;
    assign cfg_ready = !pend_vld_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = (state_q != IDLE);

    clk_div_core #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEFAULT_DIV)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .run_i      (core_run),
        .clear_i    (core_clear),
        .load_i     (core_load),
        .load_div_i (pend_div_q),
        .clk_out_o  (clk_out),
        .tick_o     (tick),
        .rise_bnd_o (rise_bnd),
        .fall_bnd_o (fall_bnd),
        .cur_div_o  (cur_div)
    );

    // Core strobes: hold low in IDLE, count in RUN, finish the phase in STOPPING.
    always_comb begin
        core_run   = 1'b0;
        core_clear = 1'b0;
        core_load  = 1'b0;
        case (state_q)
            IDLE: begin
                core_clear = 1'b1;
                core_load  = pend_vld_q;
            end
            RUN: begin
                core_run  = 1'b1;
                core_load = pend_vld_q && pend_en_q && rise_bnd;
            end
            STOPPING: begin
                if (!clk_out || fall_bnd) begin
                    core_clear = 1'b1;
                end else begin
                    core_run = 1'b1;
                end
            end
            default: core_clear = 1'b1;
        endcase
    end

    // FSM, pending request register and error pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= START_ENABLED ? RUN : IDLE;
            pend_vld_q <= 1'b0;
            pend_en_q  <= 1'b0;
            pend_div_q <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            cfg_err_q <= accept && (cfg_div == '0);
            case (state_q)
                IDLE: begin
                    if (pend_vld_q) begin
                        pend_vld_q <= 1'b0;
                        if (pend_en_q) begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (pend_vld_q) begin
                        if (!pend_en_q) begin
                            state_q <= STOPPING;
                        end else if (rise_bnd) begin
                            pend_vld_q <= 1'b0;
                        end
                    end
                end
                STOPPING: begin
                    // A high phase always runs to its falling boundary.
                    if (!clk_out || fall_bnd) begin
                        state_q    <= IDLE;
                        pend_vld_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
            // Only reachable while nothing is pending, so it never overwrites.
            if (accept && (cfg_div != '0)) begin
                pend_vld_q <= 1'b1;
                pend_en_q  <= cfg_en;
                pend_div_q <= cfg_div;
            end
        end
    end

`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    logic [15:0] edge_cnt_q;

    assign edge_cnt = edge_cnt_q;

    // Saturating count of rising edges, restarted whenever RUN is entered from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            edge_cnt_q <= '0;
        end else if (state_q == IDLE && pend_vld_q && pend_en_q) begin
            edge_cnt_q <= '0;
        end else if (tick && (edge_cnt_q != 16'hFFFF)) begin
            edge_cnt_q <= edge_cnt_q + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Self-checking bench for clk_div_ctrl: reset check, a table of per-cycle
// vectors, hand-written boundary sequences and a randomized run against a
// phase-countdown reference model.
module tb_clk_div_ctrl;

    localparam int W      = 8;
    localparam int DEFDIV = 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cfg_valid = 1'b0;
    logic         cfg_en = 1'b0;
    logic [W-1:0] cfg_div = '0;
    logic         cfg_ready;
    logic         cfg_err;
    logic         clk_out;
    logic         tick;
    logic         busy;
    logic [W-1:0] cur_div;
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
    logic [15:0]  edge_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_cyc   = 0;

    clk_div_ctrl #(
        .WIDTH         (W),
        .DEFAULT_DIV   (DEFDIV),
        .START_ENABLED (1'b0)
    ) dut (
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
        .edge_cnt  (edge_cnt),
`endif
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_en    (cfg_en),
        .cfg_div   (cfg_div),
        .cfg_err   (cfg_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .busy      (busy),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: mode 0=idle 1=run 2=stopping; m_left = cycles left in phase.
    int m_mode, m_left, m_div, p_div, m_edge;
    bit m_out, m_tick, m_err, p_vld, p_en;

    task automatic model_reset();
        m_mode = 0; m_out = 0; m_tick = 0; m_err = 0;
        p_vld = 0; p_en = 0; p_div = 0;
        m_div = DEFDIV; m_left = DEFDIV; m_edge = 0;
    endtask

    task automatic model_step();
        bit acc, bad;
        acc = cfg_valid && !p_vld;
        bad = acc && (cfg_div == 0);
        if (m_tick && m_edge < 65535) m_edge++;
        m_tick = 0;
        case (m_mode)
            0: begin
                m_out = 0;
                if (p_vld) begin
                    m_div = p_div;
                    p_vld = 0;
                    if (p_en) begin
                        m_mode = 1; m_left = m_div; m_edge = 0;
                    end
                end
            end
            1: begin
                if (p_vld && !p_en) m_mode = 2;
                if (m_left == 1) begin
                    if (!m_out) begin
                        m_out = 1; m_tick = 1;
                        if (p_vld && p_en) begin m_div = p_div; p_vld = 0; end
                    end else begin
                        m_out = 0;
                    end
                    m_left = m_div;
                end else begin
                    m_left--;
                end
            end
            default: begin
                if (!m_out || m_left == 1) begin
                    m_out = 0; m_mode = 0; p_vld = 0;
                end else begin
                    m_left--;
                end
            end
        endcase
        m_err = bad;
        if (acc && !bad) begin p_vld = 1; p_en = cfg_en; p_div = int'(cfg_div); end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d, t=%0t)", name, act, exp, n_cyc, $time);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return 32'({clk_out, tick, busy, cfg_ready, cfg_err, cur_div});
    endfunction

    function automatic logic [31:0] mk_vec(bit o, bit t, bit b, bit r, bit e, int d);
        return 32'({o, t, b, r, e, d[W-1:0]});
    endfunction

    // One clock: advance the model with the current inputs, then sample after the edge.
    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
        n_cyc++;
        check("model", dut_vec(), mk_vec(m_out, m_tick, m_mode != 0, !p_vld, m_err, m_div));
`ifdef CLK_DIV_CTRL_EDGE_CNT_EN
        check("edge_cnt", 32'(edge_cnt), 32'(m_edge));
`endif
    endtask

    task automatic send_cfg(input bit en, input int div);
        cfg_valid = 1; cfg_en = en; cfg_div = W'(div);
        cyc();
        cfg_valid = 0;
    endtask

    task automatic wait_rise(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cyc();
            seen = clk_out && tick;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    typedef struct {
        bit           v;
        bit           en;
        logic [W-1:0] div;
        bit           e_out, e_tick, e_busy, e_rdy, e_err;
        logic [W-1:0] e_div;
    } vec_t;

    vec_t tbl[14];

    initial begin
        bit rdy_prev;
        // Start from IDLE, request en=1 div=3, then a dropped div=0 request.
        tbl[0]  = '{1, 1, 8'd3, 0, 0, 0, 0, 0, 8'd1};
        tbl[1]  = '{0, 0, 8'd0, 0, 0, 1, 1, 0, 8'd3};
        tbl[2]  = '{0, 0, 8'd0, 0, 0, 1, 1, 0, 8'd3};
        tbl[3]  = '{0, 0, 8'd0, 0, 0, 1, 1, 0, 8'd3};
        tbl[4]  = '{0, 0, 8'd0, 1, 1, 1, 1, 0, 8'd3};
        tbl[5]  = '{0, 0, 8'd0, 1, 0, 1, 1, 0, 8'd3};
        tbl[6]  = '{0, 0, 8'd0, 1, 0, 1, 1, 0, 8'd3};
        tbl[7]  = '{0, 0, 8'd0, 0, 0, 1, 1, 0, 8'd3};
        tbl[8]  = '{0, 0, 8'd0, 0, 0, 1, 1, 0, 8'd3};
        tbl[9]  = '{0, 0, 8'd0, 0, 0, 1, 1, 0, 8'd3};
        tbl[10] = '{0, 0, 8'd0, 1, 1, 1, 1, 0, 8'd3};
        tbl[11] = '{0, 0, 8'd0, 1, 0, 1, 1, 0, 8'd3};
        tbl[12] = '{1, 1, 8'd0, 1, 0, 1, 1, 1, 8'd3};
        tbl[13] = '{0, 0, 8'd0, 0, 0, 1, 1, 0, 8'd3};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), mk_vec(0, 0, 0, 1, 0, DEFDIV));
        rst = 0;

        for (int i = 0; i < 14; i++) begin
            cfg_valid = tbl[i].v; cfg_en = tbl[i].en; cfg_div = tbl[i].div;
            cyc();
            check($sformatf("vec%0d", i), dut_vec(),
                  mk_vec(tbl[i].e_out, tbl[i].e_tick, tbl[i].e_busy, tbl[i].e_rdy,
                         tbl[i].e_err, int'(tbl[i].e_div)));
        end
        cfg_valid = 0;

        // div=4 running, div=1 requested mid high phase.
        send_cfg(1, 4);
        wait_rise("rise_div4");
        for (int k = 1; k < 20; k++) begin
            cfg_valid = (k == 2); cfg_en = 1; cfg_div = 8'd1;
            cyc();
            check($sformatf("div4to1_out%0d", k), 32'(clk_out),
                  32'((k < 4) ? 1 : (k < 8) ? 0 : (((k - 8) % 2) == 0) ? 1 : 0));
            if (k == 7) check("div4to1_cur7", 32'(cur_div), 32'd4);
            if (k == 8) check("div4to1_cur8", 32'(cur_div), 32'd1);
        end
        cfg_valid = 0;

        // div=5 running, stop requested one cycle into the high phase.
        send_cfg(1, 5);
        wait_rise("rise_div5");
        for (int k = 1; k < 12; k++) begin
            cfg_valid = (k == 1); cfg_en = 0; cfg_div = 8'd5;
            cyc();
            check($sformatf("stop_vec%0d", k), 32'({clk_out, tick, busy}),
                  32'({(k < 5), 1'b0, (k < 5)}));
        end
        cfg_valid = 0;

        // Asynchronous reset mid high phase at div=7 with a request pending.
        send_cfg(1, 7);
        wait_rise("rise_div7");
        cyc();
        cyc();
        send_cfg(1, 2);
        check("pending_before_rst", 32'(cfg_ready), 32'd0);
        #2;
        rst = 1;
        #1;
        check("async_rst", dut_vec(), mk_vec(0, 0, 0, 1, 0, DEFDIV));
        model_reset();
        @(posedge clk);
        #2;
        rst = 0;
        repeat (6) cyc();

        // Randomized traffic; a request is held until it is accepted.
        rdy_prev = 1;
        for (int i = 0; i < 3000; i++) begin
            if (!(cfg_valid && !rdy_prev)) begin
                cfg_valid = ($urandom_range(0, 7) == 0);
                cfg_en    = ($urandom_range(0, 3) != 0);
                cfg_div   = ($urandom_range(0, 11) == 0) ? 8'd0 : W'($urandom_range(1, 5));
            end
            rdy_prev = !p_vld;
            cyc();
        end
        cfg_valid = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
